// File: rtl/bpu_gshare_pred_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bpu_gshare_pred_unit
// Description : Gshare branch-direction predictor for the BPU front end.
//               A 2-bit saturating-counter PHT is indexed by
//               PC[PHT_IDX_WIDTH+1:2] XOR (speculative GHR folded to
//               PHT_IDX_WIDTH bits). The prediction is registered and
//               returned one cycle after the lookup is accepted. The GHR is
//               shifted speculatively with each prediction and restored
//               from a checkpoint on mispredict. After reset, a hardware
//               sweep writes CTR_INIT into every PHT entry before any lookup
//               or update is accepted.
// Ports       : clk, rst_n                    clock, async active-low reset
//               i_pred_vld, i_pred_pc         lookup request
//               o_pred_rdy                    lookup accepted (RUN only)
//               o_pred_vld/taken/ctr/idx/ghr  registered prediction result
//               i_upd_vld/idx/ctr/taken       branch resolution / PHT train
//               i_upd_mispred, i_upd_ghr      GHR recovery from checkpoint
//               o_init_busy                   PHT init sweep in progress
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_gshare_pred_unit #(
  parameter int         PC_WIDTH      = 32,
  parameter int         GHR_WIDTH     = 12,
  parameter int         PHT_IDX_WIDTH = 11,
  parameter logic [1:0] CTR_INIT      = 2'b01
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_pred_vld,
  input  logic [PC_WIDTH-1:0]      i_pred_pc,
  output logic                     o_pred_rdy,
  output logic                     o_pred_vld,
  output logic                     o_pred_taken,
  output logic [1:0]               o_pred_ctr,
  output logic [PHT_IDX_WIDTH-1:0] o_pred_idx,
  output logic [GHR_WIDTH-1:0]     o_pred_ghr,
  input  logic                     i_upd_vld,
  input  logic [PHT_IDX_WIDTH-1:0] i_upd_idx,
  input  logic [1:0]               i_upd_ctr,
  input  logic                     i_upd_taken,
  input  logic                     i_upd_mispred,
  input  logic [GHR_WIDTH-1:0]     i_upd_ghr,
  output logic                     o_init_busy
);

  localparam int c_DEPTH   = 1 << PHT_IDX_WIDTH;
  // Number of PHT_IDX_WIDTH-bit chunks covering the GHR (rounded up).
  localparam int c_N_CHUNK = (GHR_WIDTH + PHT_IDX_WIDTH - 1) / PHT_IDX_WIDTH;
  localparam int c_GHR_PAD = c_N_CHUNK * PHT_IDX_WIDTH;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [PHT_IDX_WIDTH-1:0] r_init_ptr;
  logic [GHR_WIDTH-1:0]     r_ghr;
  logic [1:0]               r_pht [c_DEPTH];

  logic                     r_pred_vld;
  logic [1:0]               r_pred_ctr;
  logic [PHT_IDX_WIDTH-1:0] r_pred_idx;
  logic [GHR_WIDTH-1:0]     r_pred_ghr;

  logic                     w_run;
  logic                     w_lkp_acc;
  logic                     w_upd_en;
  logic                     w_mispred;
  logic [c_GHR_PAD-1:0]     w_ghr_pad;
  logic [PHT_IDX_WIDTH-1:0] w_fold;
  logic [PHT_IDX_WIDTH-1:0] w_lkp_idx;
  logic [1:0]               w_upd_new;
  logic [1:0]               w_rd_ctr;
  logic                     w_wr_en;
  logic [PHT_IDX_WIDTH-1:0] w_wr_idx;
  logic [1:0]               w_wr_data;
  logic                     w_in_unused;

  // PC low bits are always zero for aligned fetch, upper PC bits do not take
  // part in the hash, and the checkpoint MSB is shifted out on recovery.
  assign w_in_unused = ^{i_pred_pc[PC_WIDTH-1:PHT_IDX_WIDTH+2], i_pred_pc[1:0],
                         i_upd_ghr[GHR_WIDTH-1]};

  // --------------------------------------------------------------------------
  // FSM: INIT sweeps the PHT, RUN serves lookups/updates until next reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_init_ptr <= r_init_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    o_pred_rdy  = 1'b0;
    o_init_busy = 1'b1;
    unique case (r_state)
      ST_INIT: begin
        // The last entry is written this cycle; lookups open next cycle.
        if (r_init_ptr == {PHT_IDX_WIDTH{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run       = 1'b1;
        o_pred_rdy  = 1'b1;
        o_init_busy = 1'b0;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Index hash: XOR-fold the zero-extended GHR down to PHT_IDX_WIDTH bits.
  // --------------------------------------------------------------------------
  assign w_ghr_pad = c_GHR_PAD'(r_ghr);

  always_comb begin
    w_fold = '0;
    for (int k = 0; k < c_N_CHUNK; k++) begin
      w_fold = w_fold ^ w_ghr_pad[k*PHT_IDX_WIDTH +: PHT_IDX_WIDTH];
    end
  end

  assign w_lkp_idx = i_pred_pc[PHT_IDX_WIDTH+1:2] ^ w_fold;
  assign w_lkp_acc = i_pred_vld & w_run;
  assign w_upd_en  = i_upd_vld & w_run;
  assign w_mispred = w_upd_en & i_upd_mispred;

  // Saturating counter update from the counter value carried with the branch.
  always_comb begin
    w_upd_new = i_upd_ctr;
    if (i_upd_taken) begin
      if (i_upd_ctr != 2'b11) w_upd_new = i_upd_ctr + 2'd1;
    end else begin
      if (i_upd_ctr != 2'b00) w_upd_new = i_upd_ctr - 2'd1;
    end
  end

  // Read with write-to-read bypass so a same-cycle update is seen by the
  // lookup instead of the stale array contents.
  assign w_rd_ctr = (w_upd_en && (i_upd_idx == w_lkp_idx)) ? w_upd_new
                                                           : r_pht[w_lkp_idx];

  // Single write port shared by the init sweep and training updates.
  assign w_wr_en   = ~w_run | w_upd_en;
  assign w_wr_idx  = w_run ? i_upd_idx : r_init_ptr;
  assign w_wr_data = w_run ? w_upd_new : CTR_INIT;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_pht[w_wr_idx] <= w_wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Speculative GHR: recovery beats a same-cycle speculative shift.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_mispred) begin
      r_ghr <= {i_upd_ghr[GHR_WIDTH-2:0], i_upd_taken};
    end else if (w_lkp_acc) begin
      r_ghr <= {r_ghr[GHR_WIDTH-2:0], w_rd_ctr[1]};
    end
  end

  // --------------------------------------------------------------------------
  // Registered prediction result.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_vld <= 1'b0;
      r_pred_ctr <= '0;
      r_pred_idx <= '0;
      r_pred_ghr <= '0;
    end else begin
      r_pred_vld <= w_lkp_acc;
      if (w_lkp_acc) begin
        r_pred_ctr <= w_rd_ctr;
        r_pred_idx <= w_lkp_idx;
        r_pred_ghr <= r_ghr;
      end
    end
  end

  assign o_pred_vld   = r_pred_vld;
  assign o_pred_ctr   = r_pred_ctr;
  assign o_pred_taken = r_pred_ctr[1];
  assign o_pred_idx   = r_pred_idx;
  assign o_pred_ghr   = r_pred_ghr;

endmodule
`default_nettype wire

// File: tb/tb_bpu_gshare_pred_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bpu_gshare_pred_unit
// Description : Self-checking bench for bpu_gshare_pred_unit. A behavioural
//               model (integer PHT array + integer GHR) predicts every result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpu_gshare_pred_unit;

  localparam int PCW   = 32;
  localparam int GW    = 12;
  localparam int IW    = 11;
  localparam int DEPTH = 1 << IW;
  localparam int GMASK = (1 << GW) - 1;

  logic          clk;
  logic          rst_n;
  logic          i_pred_vld;
  logic [PCW-1:0] i_pred_pc;
  logic          o_pred_rdy;
  logic          o_pred_vld;
  logic          o_pred_taken;
  logic [1:0]    o_pred_ctr;
  logic [IW-1:0] o_pred_idx;
  logic [GW-1:0] o_pred_ghr;
  logic          i_upd_vld;
  logic [IW-1:0] i_upd_idx;
  logic [1:0]    i_upd_ctr;
  logic          i_upd_taken;
  logic          i_upd_mispred;
  logic [GW-1:0] i_upd_ghr;
  logic          o_init_busy;

  bpu_gshare_pred_unit #(
    .PC_WIDTH(PCW), .GHR_WIDTH(GW), .PHT_IDX_WIDTH(IW), .CTR_INIT(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pred_vld(i_pred_vld), .i_pred_pc(i_pred_pc),
    .o_pred_rdy(o_pred_rdy), .o_pred_vld(o_pred_vld),
    .o_pred_taken(o_pred_taken), .o_pred_ctr(o_pred_ctr),
    .o_pred_idx(o_pred_idx), .o_pred_ghr(o_pred_ghr),
    .i_upd_vld(i_upd_vld), .i_upd_idx(i_upd_idx), .i_upd_ctr(i_upd_ctr),
    .i_upd_taken(i_upd_taken), .i_upd_mispred(i_upd_mispred),
    .i_upd_ghr(i_upd_ghr), .o_init_busy(o_init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_bad;

  // Reference model state
  int m_pht [DEPTH];
  int m_ghr;
  int m_cnt;     // cycles elapsed in the init sweep since reset release
  bit exp_vld;
  int exp_idx;
  int exp_ctr;
  int exp_ghr;

  function automatic int m_index(input logic [PCW-1:0] pc, input int ghr);
    int f;
    f = 0;
    for (int i = 0; i < GW; i++) begin
      if (((ghr >> i) & 1) != 0) f = f ^ (1 << (i % IW));
    end
    return (int'(pc >> 2) & (DEPTH - 1)) ^ f;
  endfunction

  function automatic int m_sat(input int ctr, input bit taken);
    if (taken) return (ctr == 3) ? 3 : ctr + 1;
    else       return (ctr == 0) ? 0 : ctr - 1;
  endfunction

  task automatic idle_inputs();
    i_pred_vld = 1'b0; i_pred_pc = '0;
    i_upd_vld = 1'b0; i_upd_idx = '0; i_upd_ctr = '0;
    i_upd_taken = 1'b0; i_upd_mispred = 1'b0; i_upd_ghr = '0;
  endtask

  task automatic set_upd(input bit vld, input int idx, input int ctr,
                         input bit taken, input bit mis, input int ghr);
    i_upd_vld = vld; i_upd_idx = idx[IW-1:0]; i_upd_ctr = ctr[1:0];
    i_upd_taken = taken; i_upd_mispred = mis; i_upd_ghr = ghr[GW-1:0];
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
    m_ghr = 0; m_cnt = 0; exp_vld = 1'b0;
  endtask

  // Advance the model by one cycle using the currently driven inputs, then
  // clock the DUT and settle just after the edge.
  task automatic step();
    int lc;
    lc = 0;
    exp_vld = 1'b0;
    if (m_cnt < DEPTH) begin
      m_cnt++;
    end else begin
      if (i_upd_vld) m_pht[int'(i_upd_idx)] = m_sat(int'(i_upd_ctr), i_upd_taken);
      if (i_pred_vld) begin
        exp_idx = m_index(i_pred_pc, m_ghr);
        lc      = m_pht[exp_idx];
        exp_ctr = lc;
        exp_ghr = m_ghr;
        exp_vld = 1'b1;
      end
      if (i_upd_vld && i_upd_mispred) m_ghr = ((int'(i_upd_ghr) << 1) | int'(i_upd_taken)) & GMASK;
      else if (i_pred_vld)            m_ghr = ((m_ghr << 1) | (lc >> 1)) & GMASK;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_pred_vld = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_pred_vld, o_pred_taken, o_pred_ctr, o_pred_idx, o_pred_ghr, o_pred_rdy, o_init_busy} !== {1'b0, 1'b0, 2'b00, {IW{1'b0}}, {GW{1'b0}}, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_values: vld=%b tk=%b ctr=%b idx=%h ghr=%h rdy=%b busy=%b want 0 0 00 000 000 0 1",
               o_pred_vld, o_pred_taken, o_pred_ctr, o_pred_idx, o_pred_ghr, o_pred_rdy, o_init_busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    // Updates/mispredicts during INIT must be dropped.
    set_upd(1'b1, 0, 3, 1'b1, 1'b1, 12'h7FF);
    while (m_cnt < DEPTH) begin
      n_total++;
      if (o_init_busy !== 1'b1 || o_pred_rdy !== 1'b0 || o_pred_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL init_busy cycle %0d: busy=%b rdy=%b vld=%b want 1 0 0", m_cnt, o_init_busy, o_pred_rdy, o_pred_vld);
      end
      step();
    end
    n_total++;
    if (o_init_busy !== 1'b0 || o_pred_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL init_end: busy=%b rdy=%b want 0 1", o_init_busy, o_pred_rdy);
    end
    set_upd(1'b0, 0, 0, 1'b0, 1'b0, 0);
    step();
    n_total++;
    if (o_pred_vld !== 1'b1 || o_pred_ctr !== 2'b01 || o_pred_taken !== 1'b0 ||
        o_pred_idx !== 11'h000 || o_pred_ghr !== 12'h000) begin
      n_bad++;
      $display("FAIL first_pred: vld=%b ctr=%b tk=%b idx=%h ghr=%h want 1 01 0 000 000",
               o_pred_vld, o_pred_ctr, o_pred_taken, o_pred_idx, o_pred_ghr);
    end
  endtask

  task automatic test_lookup();
    idle_inputs();
    i_pred_vld = 1'b1; i_pred_pc = 32'h0000_1004;
    step();
    n_total++;
    if (o_pred_vld !== 1'b1 || o_pred_idx !== 11'h401 || o_pred_ghr !== 12'h000 || o_pred_ctr !== 2'b01) begin
      n_bad++;
      $display("FAIL lookup_basic: vld=%b idx=%h ghr=%h ctr=%b want 1 401 000 01",
               o_pred_vld, o_pred_idx, o_pred_ghr, o_pred_ctr);
    end
    idle_inputs();
    step();
    n_total++;
    if (o_pred_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_vld: vld=%b want 0", o_pred_vld);
    end
  endtask

  task automatic test_update_sat();
    int want [3];
    int uc [3];
    bit ut [3];
    want = '{3, 0, 2}; uc = '{3, 0, 1}; ut = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      // Train the entry; a mispredict to checkpoint 0 keeps the GHR at 0.
      idle_inputs();
      set_upd(1'b1, 12'h401, uc[k], ut[k], 1'b1, 0);
      i_upd_taken = 1'b0;
      step();
      // Second cycle applies the intended direction without GHR impact.
      set_upd(1'b1, 12'h401, uc[k], ut[k], 1'b0, 0);
      if (k == 1) set_upd(1'b1, 12'h401, uc[k], ut[k], 1'b0, 0);
      step();
      idle_inputs();
      i_pred_vld = 1'b1; i_pred_pc = 32'h0000_1004;
      step();
      n_total++;
      if (o_pred_vld !== 1'b1 || o_pred_idx !== 11'h401 || int'(o_pred_ctr) != want[k] ||
          o_pred_taken !== want[k][1]) begin
        n_bad++;
        $display("FAIL update_sat[%0d]: vld=%b idx=%h ctr=%0d tk=%b want 1 401 %0d %b",
                 k, o_pred_vld, o_pred_idx, o_pred_ctr, o_pred_taken, want[k], want[k][1]);
      end
      // Return GHR to zero for the next case.
      idle_inputs();
      set_upd(1'b1, 12'h7FF, 0, 1'b0, 1'b1, 0);
      step();
    end
  endtask

  task automatic test_ghr_mispred();
    bit want_tk [3];
    int want_g [3];
    want_tk = '{1'b1, 1'b0, 1'b1}; want_g = '{0, 1, 2};
    idle_inputs();
    set_upd(1'b1, 12'h100, 2, 1'b1, 1'b0, 0); step();
    set_upd(1'b1, 12'h101, 0, 1'b0, 1'b0, 0); step();
    set_upd(1'b1, 12'h102, 2, 1'b1, 1'b0, 0); step();
    set_upd(1'b1, 12'h7FF, 0, 1'b0, 1'b1, 0); step();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      i_pred_vld = 1'b1; i_pred_pc = 32'h0000_0400;
      step();
      n_total++;
      if (o_pred_vld !== 1'b1 || o_pred_taken !== want_tk[k] || int'(o_pred_ghr) != want_g[k]) begin
        n_bad++;
        $display("FAIL ghr_spec[%0d]: vld=%b tk=%b ghr=%h want 1 %b %h",
                 k, o_pred_vld, o_pred_taken, o_pred_ghr, want_tk[k], want_g[k]);
      end
    end
    // Lookup and mispredict in the same cycle.
    set_upd(1'b1, 12'h7FF, 0, 1'b0, 1'b1, 12'h001);
    step();
    n_total++;
    if (o_pred_vld !== 1'b1 || o_pred_ghr !== 12'h005) begin
      n_bad++;
      $display("FAIL ghr_pre_recover: vld=%b ghr=%h want 1 005", o_pred_vld, o_pred_ghr);
    end
    set_upd(1'b0, 0, 0, 1'b0, 1'b0, 0);
    step();
    n_total++;
    if (o_pred_vld !== 1'b1 || o_pred_ghr !== 12'h002) begin
      n_bad++;
      $display("FAIL ghr_recovered: vld=%b ghr=%h want 1 002", o_pred_vld, o_pred_ghr);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    // Entry 0x401 -> 0 and GHR -> 0 so the bypassed value differs from storage.
    set_upd(1'b1, 12'h401, 1, 1'b0, 1'b1, 0);
    step();
    set_upd(1'b1, 12'h401, 1, 1'b1, 1'b0, 0);
    i_pred_vld = 1'b1; i_pred_pc = 32'h0000_1004;
    step();
    n_total++;
    if (o_pred_vld !== 1'b1 || o_pred_idx !== 11'h401 || o_pred_ctr !== 2'b10 || o_pred_taken !== 1'b1) begin
      n_bad++;
      $display("FAIL bypass: vld=%b idx=%h ctr=%b tk=%b want 1 401 10 1",
               o_pred_vld, o_pred_idx, o_pred_ctr, o_pred_taken);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back_random();
    int cidx;
    for (int c = 0; c < 800; c++) begin
      i_pred_vld = ($urandom_range(3) != 0);
      i_pred_pc  = $urandom;
      cidx = m_index(i_pred_pc, m_ghr);
      i_upd_vld     = $urandom_range(1);
      i_upd_idx     = ($urandom_range(3) == 0) ? cidx[IW-1:0] : IW'($urandom);
      i_upd_ctr     = 2'($urandom);
      i_upd_taken   = $urandom_range(1);
      i_upd_mispred = ($urandom_range(3) == 0);
      i_upd_ghr     = GW'($urandom);
      step();
      n_total++;
      if (o_pred_vld !== exp_vld) begin
        n_bad++;
        $display("FAIL rand_vld cyc %0d: vld=%b want %b", c, o_pred_vld, exp_vld);
      end
      if (exp_vld) begin
        n_total++;
        if (o_pred_idx !== exp_idx[IW-1:0] || o_pred_ctr !== exp_ctr[1:0] ||
            o_pred_taken !== exp_ctr[1] || o_pred_ghr !== exp_ghr[GW-1:0]) begin
          n_bad++;
          $display("FAIL rand_pred cyc %0d: idx=%h ctr=%b tk=%b ghr=%h want %h %b %b %h",
                   c, o_pred_idx, o_pred_ctr, o_pred_taken, o_pred_ghr,
                   exp_idx[IW-1:0], exp_ctr[1:0], exp_ctr[1], exp_ghr[GW-1:0]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_init();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    i_pred_vld = 1'b1;
    repeat (700) step();
    rst_n = 1'b0;
    #1;
    n_total++;
    if (o_init_busy !== 1'b1 || o_pred_rdy !== 1'b0 || o_pred_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_init_reset: busy=%b rdy=%b vld=%b want 1 0 0", o_init_busy, o_pred_rdy, o_pred_vld);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    while (m_cnt < DEPTH) begin
      n_total++;
      if (o_init_busy !== 1'b1 || o_pred_rdy !== 1'b0) begin
        n_bad++;
        $display("FAIL reinit_busy cycle %0d: busy=%b rdy=%b want 1 0", m_cnt, o_init_busy, o_pred_rdy);
      end
      step();
    end
    n_total++;
    if (o_init_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reinit_end: busy=%b want 0", o_init_busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      i_pred_pc = PCW'(i << 2);
      step();
      n_total++;
      if (o_pred_vld !== 1'b1 || int'(o_pred_idx) != i || o_pred_ctr !== 2'b01) begin
        n_bad++;
        $display("FAIL reinit_entry %0d: vld=%b idx=%h ctr=%b want 1 %h 01", i, o_pred_vld, o_pred_idx, o_pred_ctr, i);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_lookup();
    test_update_sat();
    test_ghr_mispred();
    test_bypass();
    test_back_to_back_random();
    test_reset_mid_init();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
